// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and activation helpers (ReLU, 16-bit saturation).
package cnn_pkg;
  localparam int ACC_W = 32;
  localparam int PIX_W = 16;
  localparam logic [PIX_W-1:0] PIX_MAX = 16'h7FFF;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [ACC_W-1:0] uacc_t;
  typedef logic signed [PIX_W-1:0] pix_t;

  function automatic uacc_t relu(input acc_t x);
    return x[ACC_W-1] ? '0 : uacc_t'(x);
  endfunction

  // Inputs are post-ReLU, so only the upper bound needs clamping.
  function automatic pix_t sat16(input uacc_t v);
    return (v > uacc_t'(PIX_MAX)) ? pix_t'(PIX_MAX) : pix_t'(v[PIX_W-1:0]);
  endfunction

  function automatic uacc_t umax(input uacc_t a, input uacc_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// Conv-result in / pooled-activation out stream for relu_maxpool_2x2.
interface relu_maxpool_2x2_if;
  import cnn_pkg::*;
  acc_t input_port;
  logic in_invalid;
  pix_t output_port;
  logic invalid;
  logic finish;

  modport master (output input_port, in_invalid, input output_port, invalid, finish);
  modport slave  (input input_port, in_invalid, output output_port, invalid, finish);
endinterface

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the even-row pair maxima; async read, no reset.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  uacc_t         wdata,
  output uacc_t         rdata
);
  uacc_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool + shift/saturate to 16 bits.
module relu_maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int SHIFT = 8
) (
  input  logic clk,
  input  logic reset,
  relu_maxpool_2x2_if.slave bus
);
  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1)  ? $clog2(IMG_W)  : 1;
  localparam int RW     = (IMG_H > 1)  ? $clog2(IMG_H)  : 1;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  uacc_t         hold;
  uacc_t         lb_rd;
  pix_t          out_q;
  logic          inv_q, fin_q, fin_pend;

  logic  acc, col_last, row_last, lb_we, win_done;
  uacc_t rx, pair_max, win_max;

  assign acc      = !bus.in_invalid;
  assign rx       = relu(bus.input_port);
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign lb_we    = acc && !row[0] && col[0];
  assign win_done = acc &&  row[0] && col[0];
  assign pair_max = umax(hold, rx);
  assign win_max  = umax(lb_rd, pair_max);

  pool_line_buf #(.DEPTH(HALF_W), .AW(AW)) u_lb (
    .clk  (clk),
    .we   (lb_we),
    .idx  (AW'(col >> 1)),
    .wdata(pair_max),
    .rdata(lb_rd)
  );

  // finish trails the last window's output by one cycle via fin_pend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      hold     <= '0;
      out_q    <= '0;
      inv_q    <= 1'b1;
      fin_q    <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      inv_q    <= !win_done;
      fin_q    <= fin_pend;
      fin_pend <= win_done && row_last && col_last;
      if (win_done) out_q <= sat16(win_max >> SHIFT);
      if (acc) begin
        if (!col[0]) hold <= rx;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.output_port = out_q;
  assign bus.invalid     = inv_q;
  assign bus.finish      = fin_q;
endmodule
